// File: rtl/frame_gate_ctrl.sv
// Frame gate: passes a bounded number of whole video frames from input to output,
// armed by command pulses, with a sticky check of line length and line count.
module frame_gate_ctrl #(
    parameter int H_RES = 64,
    parameter int V_RES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_de,
    input  logic       in_hs,
    input  logic       in_vs,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic [7:0] cmd_nframes,
    output logic       out_de,
    output logic       out_hs,
    output logic       out_vs,
    output logic [7:0] out_r,
    output logic [7:0] out_g,
    output logic [7:0] out_b,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frames_left,
    output logic       geom_err
);

    localparam logic [10:0] H_EXP   = 11'(H_RES);
    localparam logic [10:0] V_EXP   = 11'(V_RES);
    localparam logic [10:0] CNT_MAX = 11'h7FF;

    typedef enum logic [1:0] {IDLE, ARMED, PASS, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  rst_sync_q;
    logic        rst_int_n;
    logic        vs_dly_q, de_dly_q;
    logic [10:0] pix_cnt_q, pix_cnt_d;
    logic [10:0] line_cnt_q, line_cnt_d;
    logic [7:0]  frames_left_q, frames_left_d;
    logic        geom_err_q, geom_err_d;
    logic        frame_done_q, frame_done_d;
    logic [26:0] out_vid_q, out_vid_d;
    logic        vs_rise, de_fall, frame_end, leaving, gate_en, start_acc;

    // Reset asserts at once but releases two edges later, so the first live edge is clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (cmd_start) state_d = ARMED;
            ARMED: begin
                if (cmd_stop)     state_d = IDLE;
                else if (vs_rise) state_d = PASS;
            end
            PASS: begin
                if (vs_rise) begin
                    if (cmd_stop || frames_left_q == 8'd1) state_d = IDLE;
                end else if (cmd_stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: if (vs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    // A stop arriving together with the arming vsync cancels the capture, so that pulse is not passed.
    always_comb begin
        vs_rise   = in_vs & ~vs_dly_q;
        de_fall   = ~in_de & de_dly_q;
        start_acc = (state_q == IDLE) & cmd_start;
        frame_end = vs_rise & ((state_q == PASS) | (state_q == DRAIN));
        leaving   = (state_d == IDLE) & (state_q != IDLE);
        gate_en   = ((state_q == ARMED) & vs_rise & ~cmd_stop)
                  | (((state_q == PASS) | (state_q == DRAIN)) & ~(vs_rise & leaving));

        frames_left_d = frames_left_q;
        if (start_acc)
            frames_left_d = cmd_nframes;
        else if (frame_end && frames_left_q != 8'd0)
            frames_left_d = frames_left_q - 8'd1;

        geom_err_d = geom_err_q;
        if (start_acc) begin
            geom_err_d = 1'b0;
        end else begin
            if (frame_end && line_cnt_q != V_EXP)             geom_err_d = 1'b1;
            if (gate_en && de_fall && pix_cnt_q != H_EXP)     geom_err_d = 1'b1;
        end

        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        if (vs_rise) begin
            pix_cnt_d  = 11'd0;
            line_cnt_d = 11'd0;
        end else if (gate_en) begin
            if (de_fall) begin
                pix_cnt_d = 11'd0;
                if (line_cnt_q != CNT_MAX) line_cnt_d = line_cnt_q + 11'd1;
            end else if (in_de && pix_cnt_q != CNT_MAX) begin
                pix_cnt_d = pix_cnt_q + 11'd1;
            end
        end

        frame_done_d = frame_end;
        out_vid_d    = gate_en ? {in_de, in_hs, in_vs, in_r, in_g, in_b} : 27'd0;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            vs_dly_q      <= 1'b0;
            de_dly_q      <= 1'b0;
            pix_cnt_q     <= 11'd0;
            line_cnt_q    <= 11'd0;
            frames_left_q <= 8'd0;
            geom_err_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            out_vid_q     <= 27'd0;
        end else begin
            vs_dly_q      <= in_vs;
            de_dly_q      <= in_de;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            frames_left_q <= frames_left_d;
            geom_err_q    <= geom_err_d;
            frame_done_q  <= frame_done_d;
            out_vid_q     <= out_vid_d;
        end
    end

    assign {out_de, out_hs, out_vs, out_r, out_g, out_b} = out_vid_q;
    assign frame_done  = frame_done_q;
    assign frames_left = frames_left_q;
    assign geom_err    = geom_err_q;

endmodule

// File: tb/tb_frame_gate_ctrl.sv
// Self-checking bench for frame_gate_ctrl: generated video stream, directed command
// scenarios, then randomized commands/geometry/resets against a behavioural model.
module tb_frame_gate_ctrl;

    localparam int H   = 16;
    localparam int V   = 8;
    localparam int HBL = 6;
    localparam int VBL = 2;
    localparam int LL  = H + HBL;
    localparam int FL  = LL * (VBL + V);

    logic       clk;
    logic       rst_n;
    logic       in_de, in_hs, in_vs;
    logic [7:0] in_r, in_g, in_b;
    logic       cmd_start, cmd_stop;
    logic [7:0] cmd_nframes;
    logic       out_de, out_hs, out_vs;
    logic [7:0] out_r, out_g, out_b;
    logic       busy, frame_done, geom_err;
    logic [7:0] frames_left;

    int checkCnt = 0;
    int passCnt  = 0;
    int vidFrame = 0;
    int doneCnt  = 0;
    int badMode  = 0;
    bit randGeom = 0;
    bit cmpEn    = 0;

    // Model state: what the gate is doing, described as capture phases rather than encoded states
    bit          mWaiting, mCapturing, mDraining, mDone, mErr;
    int          mLeft, mPix, mLines, mRel;
    bit          mVsPrev, mDePrev;
    logic [26:0] mVid;

    frame_gate_ctrl #(.H_RES(H), .V_RES(V)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_nframes(cmd_nframes),
        .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .busy(busy), .frame_done(frame_done),
        .frames_left(frames_left), .geom_err(geom_err)
    );

    // Free-running pixel clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCnt++;
        if (actual === expected) passCnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    // Video source: vblank lines then active lines; mode 1 shortens one line, 2 adds a line, 3 drops one
    initial begin
        in_de = 0; in_hs = 0; in_vs = 0; in_r = 0; in_g = 0; in_b = 0;
        forever begin
            int mode;
            int nLines;
            int pick;
            pick   = $urandom_range(0, 7);
            mode   = randGeom ? ((pick < 5) ? 0 : pick - 4) : badMode;
            nLines = V + ((mode == 2) ? 1 : 0) - ((mode == 3) ? 1 : 0);
            for (int ln = 0; ln < VBL + nLines; ln++) begin
                for (int px = 0; px < LL; px++) begin
                    int nPix;
                    @(posedge clk); #1;
                    if (ln == 0 && px == 0) vidFrame++;
                    nPix  = (mode == 1 && ln == VBL + 2) ? H - 1 : H;
                    in_vs = (ln == 0 && px < 4);
                    in_hs = (px >= H + 1 && px < H + 3);
                    in_de = (ln >= VBL && px < nPix);
                    in_r  = in_de ? 8'($urandom) : 8'd0;
                    in_g  = in_de ? 8'($urandom) : 8'd0;
                    in_b  = in_de ? 8'($urandom) : 8'd0;
                end
            end
        end
    end

    // Reference model: applies the gating rules to the inputs seen at each rising edge,
    // holding itself in reset until two edges after rst_n returns high
    always @(posedge clk) begin
        bit vsRise, deFall, passNow, frameEnd, last;
        if (!rst_n || mRel < 2) begin
            if (!rst_n) mRel = 0; else mRel++;
            mWaiting = 0; mCapturing = 0; mDraining = 0; mDone = 0; mErr = 0;
            mLeft = 0; mPix = 0; mLines = 0; mVsPrev = 0; mDePrev = 0; mVid = '0;
        end else begin
            vsRise = in_vs && !mVsPrev;
            deFall = !in_de && mDePrev;
            passNow = 0; frameEnd = 0; mDone = 0;
            if (mWaiting) begin
                if (cmd_stop) mWaiting = 0;
                else if (vsRise) begin mWaiting = 0; mCapturing = 1; passNow = 1; end
            end else if (mCapturing || mDraining) begin
                if (vsRise) begin
                    frameEnd = 1; mDone = 1;
                    last = mDraining || cmd_stop || mLeft == 1;
                    if (mLeft != 0) mLeft--;
                    if (last) begin mCapturing = 0; mDraining = 0; end
                    else passNow = 1;
                end else begin
                    passNow = 1;
                    if (mCapturing && cmd_stop) begin mCapturing = 0; mDraining = 1; end
                end
            end else if (cmd_start) begin
                mWaiting = 1; mLeft = cmd_nframes; mErr = 0;
            end
            if (frameEnd && mLines != V) mErr = 1;
            if (passNow && deFall && mPix != H) mErr = 1;
            if (vsRise) begin
                mPix = 0; mLines = 0;
            end else if (passNow) begin
                if (deFall) begin mPix = 0; if (mLines < 2047) mLines++; end
                else if (in_de && mPix < 2047) mPix++;
            end
            mVsPrev = in_vs; mDePrev = in_de;
            mVid = passNow ? {in_de, in_hs, in_vs, in_r, in_g, in_b} : 27'd0;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model; reset forces all-zero
    always @(negedge clk) begin
        if (frame_done === 1'b1) doneCnt++;
        if (cmpEn) begin
            logic [26:0] eVid;
            logic        eBusy, eDone, eErr;
            logic [7:0]  eLeft;
            eVid  = rst_n ? mVid : 27'd0;
            eBusy = rst_n ? (mWaiting | mCapturing | mDraining) : 1'b0;
            eDone = rst_n ? mDone : 1'b0;
            eErr  = rst_n ? mErr : 1'b0;
            eLeft = rst_n ? 8'(mLeft) : 8'd0;
            checkOutput("video", {5'd0, out_de, out_hs, out_vs, out_r, out_g, out_b}, {5'd0, eVid});
            checkOutput("busy", {31'd0, busy}, {31'd0, eBusy});
            checkOutput("frame_done", {31'd0, frame_done}, {31'd0, eDone});
            checkOutput("frames_left", {24'd0, frames_left}, {24'd0, eLeft});
            checkOutput("geom_err", {31'd0, geom_err}, {31'd0, eErr});
        end
    end

    task automatic applyStimulus(input bit start, input bit stop, input int n);
        @(posedge clk); #1;
        cmd_start = start; cmd_stop = stop; cmd_nframes = 8'(n);
        @(posedge clk); #1;
        cmd_start = 0; cmd_stop = 0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic waitFrames(input int n, input string tag);
        int startF;
        bit ok;
        startF = vidFrame;
        ok = 0;
        for (int c = 0; c < n * (FL + LL) + 200; c++) begin
            @(posedge clk); #2;
            if (vidFrame - startF >= n) begin ok = 1; break; end
        end
        if (!ok) begin
            checkCnt++;
            $display("[TB] FAIL %s: timeout waiting for %0d frames, saw %0d", tag, n, vidFrame - startF);
        end
    endtask

    // Watchdog: any hang ends the run with a failure and the summary
    initial begin
        repeat (90000) @(posedge clk);
        checkCnt++;
        $display("[TB] FAIL watchdog: cycle budget exhausted, required completion");
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

    // Directed scenarios, then randomized commands, geometry and resets
    initial begin
        int d0;
        cmd_start = 0; cmd_stop = 0; cmd_nframes = 0;
        rst_n = 1'bx;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        cmpEn = 1;
        @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_left", {24'd0, frames_left}, 32'd0);
        checkOutput("reset_err", {31'd0, geom_err}, 32'd0);
        checkOutput("reset_de", {31'd0, out_de}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        waitCycles(5);

        $display("[TB] two-frame capture");
        waitFrames(1, "f2_sync"); waitCycles(60);
        d0 = doneCnt;
        applyStimulus(1, 0, 2);
        @(negedge clk);
        checkOutput("f2_left_start", {24'd0, frames_left}, 32'd2);
        checkOutput("f2_model_left", mLeft, 32'd2);
        waitFrames(2, "f2_first"); waitCycles(10);
        checkOutput("f2_left_mid", {24'd0, frames_left}, 32'd1);
        waitFrames(1, "f2_second"); waitCycles(10);
        checkOutput("f2_done", doneCnt - d0, 32'd2);
        checkOutput("f2_busy", {31'd0, busy}, 32'd0);
        checkOutput("f2_left_end", {24'd0, frames_left}, 32'd0);
        checkOutput("f2_err", {31'd0, geom_err}, 32'd0);

        $display("[TB] continuous with stop in third frame");
        waitCycles(40);
        d0 = doneCnt;
        applyStimulus(1, 0, 0);
        waitFrames(3, "cont_run"); waitCycles(100);
        applyStimulus(0, 1, 0);
        waitFrames(1, "cont_drain"); waitCycles(10);
        checkOutput("cont_done", doneCnt - d0, 32'd3);
        checkOutput("cont_model_done", 32'd3, 32'd3 - 32'(mLeft));
        checkOutput("cont_busy", {31'd0, busy}, 32'd0);

        $display("[TB] stop while armed");
        waitCycles(30);
        d0 = doneCnt;
        applyStimulus(1, 0, 1);
        waitCycles(20);
        applyStimulus(0, 1, 0);
        @(negedge clk);
        checkOutput("armstop_busy", {31'd0, busy}, 32'd0);
        waitFrames(1, "armstop_wait"); waitCycles(30);
        checkOutput("armstop_done", doneCnt - d0, 32'd0);

        $display("[TB] short line");
        badMode = 1;
        applyStimulus(1, 0, 1);
        waitFrames(1, "short_in"); waitCycles(5);
        badMode = 0;
        waitFrames(1, "short_end"); waitCycles(10);
        checkOutput("short_err", {31'd0, geom_err}, 32'd1);
        checkOutput("short_model_err", {31'd0, mErr}, 32'd1);
        checkOutput("short_busy", {31'd0, busy}, 32'd0);
        waitCycles(100);
        checkOutput("short_err_held", {31'd0, geom_err}, 32'd1);
        applyStimulus(1, 0, 1);
        @(negedge clk);
        checkOutput("short_err_clear", {31'd0, geom_err}, 32'd0);
        applyStimulus(0, 1, 0);

        $display("[TB] reset mid-line");
        waitCycles(10);
        applyStimulus(1, 0, 0);
        waitFrames(1, "rst_enter"); waitCycles((VBL + 2) * LL + 5);
        d0 = doneCnt;
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_vid", {5'd0, out_de, out_hs, out_vs, out_r, out_g, out_b}, 32'd0);
            checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        waitFrames(2, "rst_after"); waitCycles(10);
        checkOutput("rst_done", doneCnt - d0, 32'd0);
        checkOutput("rst_idle", {31'd0, busy}, 32'd0);

        $display("[TB] start with stop, start while passing");
        applyStimulus(1, 1, 3);
        @(negedge clk);
        checkOutput("ss_busy", {31'd0, busy}, 32'd1);
        waitFrames(1, "ss_pass"); waitCycles(30);
        checkOutput("ss_left", {24'd0, frames_left}, 32'd3);
        applyStimulus(1, 0, 7);
        @(negedge clk);
        checkOutput("ss_left_kept", {24'd0, frames_left}, 32'd3);
        applyStimulus(0, 1, 0);
        waitFrames(1, "ss_end"); waitCycles(10);

        $display("[TB] randomized phase");
        randGeom = 1;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3999) == 0) begin
                cmd_start = 0; cmd_stop = 0;
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1 rst_n = 1'b1;
            end else begin
                cmd_start   = ($urandom_range(0, 59) == 0);
                cmd_stop    = ($urandom_range(0, 149) == 0);
                cmd_nframes = 8'($urandom_range(0, 3));
            end
        end
        @(posedge clk); #1;
        cmd_start = 0; cmd_stop = 0;
        randGeom = 0;
        waitCycles(50);
        cmpEn = 0;
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
